// File: rtl/rf_nr_1w_sc_pkg.sv
// Shared constants for the multi-read, single-write register file with clear sweep.
package rf_nr_1w_sc_pkg;

    localparam int RF_WIDTH_DEF  = 32;
    localparam int RF_ADDR_W_DEF = 5;
    localparam int RF_NUM_RD_DEF = 2;
    localparam int RF_BYPASS_DEF = 1;

    localparam logic RF_STATE_IDLE  = 1'b0;
    localparam logic RF_STATE_CLEAR = 1'b1;

    typedef enum logic {
        ST_IDLE  = RF_STATE_IDLE,
        ST_CLEAR = RF_STATE_CLEAR
    } rf_state_e;

endpackage

// File: rtl/rf_nr_1w_sc_clear_seq.sv
// Clear sequencer: owns the IDLE/CLEAR state and sweep index, and muxes the
// single array write port between the user write and the zeroing sweep.
module rf_clear_seq
    import rf_nr_1w_sc_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH_DEF,
    parameter int ADDR_W = RF_ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_req_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    output logic              busy_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [WIDTH-1:0]  wdata_o
);

    localparam logic [ADDR_W-1:0] IDX_LAST = '1;
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    rf_state_e         state_q;
    logic [ADDR_W-1:0] clr_idx_q;
    logic              busy_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear_req_i) begin
                        state_q   <= ST_CLEAR;
                        clr_idx_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // clear_req is deliberately not looked at here: no restart mid-sweep
                    clr_idx_q <= clr_idx_q + IDX_ONE;
                    if (clr_idx_q == IDX_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy_o = busy_q;

    // The sweep owns the write port while clearing; user writes are dropped then.
    always_comb begin
        we_o    = 1'b0;
        waddr_o = wr_addr_i;
        wdata_o = wr_data_i;
        if (!rst_i) begin
            if (state_q == ST_CLEAR) begin
                we_o    = 1'b1;
                waddr_o = clr_idx_q;
                wdata_o = '0;
            end else begin
                we_o = wr_en_i;
            end
        end
    end

endmodule

// File: rtl/rf_nr_1w_sc.sv
// Register file: NUM_RD registered read ports, one write port, optional
// write-to-read bypass and a full-array clear sweep.
module rf_nr_1w_sc
    import rf_nr_1w_sc_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH_DEF,
    parameter int ADDR_W = RF_ADDR_W_DEF,
    parameter int NUM_RD = RF_NUM_RD_DEF,
    parameter int BYPASS = RF_BYPASS_DEF
) (
    input  logic                     rf_clock,
    input  logic                     rf_reset,
    input  logic [NUM_RD*ADDR_W-1:0] rf_rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rf_rd_data,
    input  logic                     rf_wr_enable,
    input  logic [ADDR_W-1:0]        rf_wr_addr,
    input  logic [WIDTH-1:0]         rf_wr_data,
    input  logic                     rf_clear_req,
    output logic                     rf_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;

    rf_clear_seq #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk_i       (rf_clock),
        .rst_i       (rf_reset),
        .clear_req_i (rf_clear_req),
        .wr_en_i     (rf_wr_enable),
        .wr_addr_i   (rf_wr_addr),
        .wr_data_i   (rf_wr_data),
        .busy_o      (rf_busy),
        .we_o        (we),
        .waddr_o     (waddr),
        .wdata_o     (wdata)
    );

    always_ff @(posedge rf_clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  rd_d;
        logic [WIDTH-1:0]  rd_q;

        assign ra = rf_rd_addr[p*ADDR_W +: ADDR_W];

        // rf_busy is the registered CLEAR state, so it masks reads for the whole sweep
        always_comb begin
            rd_d = mem_q[ra];
            if (BYPASS != 0 && we && waddr == ra) begin
                rd_d = wdata;
            end
            if (rf_busy) begin
                rd_d = '0;
            end
        end

        always_ff @(posedge rf_clock) begin
            if (rf_reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rf_rd_data[p*WIDTH +: WIDTH] = rd_q;
    end

endmodule
